// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared widths, state enum and port indices for the data-memory arbiter
package dmem_arbiter_pkg;

  localparam int DMEM_DATA_WIDTH = 16;
  localparam int DMEM_ADDR_WIDTH = 16;
  localparam int DMEM_LOCK_MAX   = 8;

  localparam int PORT0 = 0;
  localparam int PORT1 = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

endpackage

// File: rtl/dmem_arb_rr.sv
// rtl/dmem_arb_rr.sv - round-robin/lock grant engine: owner FSM, tie pointer and lock beat counter
module dmem_arb_rr
  import dmem_arbiter_pkg::*;
#(
  parameter int LOCK_MAX = DMEM_LOCK_MAX
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [1:0] lock,
  output logic [1:0] gnt
);

  localparam int CW = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_MAX);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  arb_state_e    state_q, state_d;
  logic          prio_q, prio_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;

  always_comb begin
    gnt = 2'b00;
    case (state_q)
      OWN0:    gnt[PORT0] = req[PORT0];
      OWN1:    gnt[PORT1] = req[PORT1];
      default: gnt = (req == 2'b11) ? (prio_q ? 2'b10 : 2'b01) : req;
    endcase
    // Grants are combinational, so reset must mask them directly.
    if (!rst) gnt = 2'b00;
  end

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    cnt_d   = cnt_q;
    cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
    if (gnt[PORT0])      prio_d = 1'b1;
    else if (gnt[PORT1]) prio_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // The entry beat is the first beat of the burst, so the count starts at one.
        if ((gnt & lock) != 2'b00) begin
          cnt_d = CNT_ONE;
          if (LOCK_MAX > 1) state_d = gnt[PORT0] ? OWN0 : OWN1;
        end
      end
      OWN0: begin
        if (gnt[PORT0]) cnt_d = cnt_inc;
        if (!gnt[PORT0] || !lock[PORT0] || (cnt_inc == CNT_MAX)) state_d = IDLE;
      end
      OWN1: begin
        if (gnt[PORT1]) cnt_d = cnt_inc;
        if (!gnt[PORT1] || !lock[PORT1] || (cnt_inc == CNT_MAX)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port data-memory arbiter with lockable bursts; DMEM_ARB_PERF_EN adds grant/stall counters
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DMEM_DATA_WIDTH,
  parameter int ADDR_WIDTH = DMEM_ADDR_WIDTH,
  parameter int LOCK_MAX   = DMEM_LOCK_MAX
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  lock0,
  input  logic                  lock1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]           grant_cnt0,
  output logic [31:0]           grant_cnt1,
  output logic [31:0]           stall_cnt0,
  output logic [31:0]           stall_cnt1
`endif
);

  logic [1:0]            gnt;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  rvalid0_q, rvalid0_d;
  logic                  rvalid1_q, rvalid1_d;

  dmem_arb_rr #(.LOCK_MAX(LOCK_MAX)) u_rr (
    .clk  (clk),
    .rst  (rst),
    .req  ({req1, req0}),
    .lock ({lock1, lock0}),
    .gnt  (gnt)
  );

  assign gnt0 = gnt[PORT0];
  assign gnt1 = gnt[PORT1];

  // Idle cycles replay the last granted address/data with write-enable low.
  always_comb begin
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    mem_we    = 1'b0;
    rvalid0_d = gnt0 & ~we0;
    rvalid1_d = gnt1 & ~we1;
    if (gnt0) begin
      addr_d  = addr0;
      wdata_d = wdata0;
      mem_we  = we0;
    end else if (gnt1) begin
      addr_d  = addr1;
      wdata_d = wdata1;
      mem_we  = we1;
    end
  end

  assign mem_addr  = addr_d;
  assign mem_wdata = wdata_d;
  assign rvalid0   = rvalid0_q;
  assign rvalid1   = rvalid1_q;
  assign rdata     = (rvalid0_q | rvalid1_q) ? mem_rdata : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
    end
  end

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] grant_cnt0_q, grant_cnt0_d, grant_cnt1_q, grant_cnt1_d;
  logic [31:0] stall_cnt0_q, stall_cnt0_d, stall_cnt1_q, stall_cnt1_d;

  always_comb begin
    grant_cnt0_d = sat_inc(grant_cnt0_q, gnt0);
    grant_cnt1_d = sat_inc(grant_cnt1_q, gnt1);
    stall_cnt0_d = sat_inc(stall_cnt0_q, req0 & ~gnt0);
    stall_cnt1_d = sat_inc(stall_cnt1_q, req1 & ~gnt1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_cnt0_q <= '0;
      grant_cnt1_q <= '0;
      stall_cnt0_q <= '0;
      stall_cnt1_q <= '0;
    end else begin
      grant_cnt0_q <= grant_cnt0_d;
      grant_cnt1_q <= grant_cnt1_d;
      stall_cnt0_q <= stall_cnt0_d;
      stall_cnt1_q <= stall_cnt1_d;
    end
  end

  assign grant_cnt0 = grant_cnt0_q;
  assign grant_cnt1 = grant_cnt1_q;
  assign stall_cnt0 = stall_cnt0_q;
  assign stall_cnt1 = stall_cnt1_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed and randomized bench for dmem_arbiter against a behavioural arbitration model
module tb_dmem_arbiter;

  localparam int LOCK_MAX = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = '0, lock = '0, we = '0;
  logic [15:0] addr [2];
  logic [15:0] wdata [2];
  logic        gnt0, gnt1, rvalid0, rvalid1, mem_we;
  logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata;
`ifdef DMEM_ARB_PERF_EN
  logic [31:0] grant_cnt0, grant_cnt1, stall_cnt0, stall_cnt1;
  int          pg [2];
  int          ps [2];
`endif

  logic [15:0] mem [0:65535];
  logic [15:0] ref_mem [0:65535];
  logic [15:0] raddr_q = '0;
  bit          mem_init = 1'b0;

  int          checks = 0, passes = 0, fails = 0;
  int          own, prio, beats, g, we_cnt;
  logic [1:0]  exp_rv;
  logic [15:0] exp_rdata, last_addr, last_wdata;
  logic        obs_g0, obs_g1;
  logic [11:0] hist0, hist1;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req[0]), .req1(req[1]), .lock0(lock[0]), .lock1(lock[1]),
    .we0(we[0]), .we1(we[1]), .addr0(addr[0]), .addr1(addr[1]),
    .wdata0(wdata[0]), .wdata1(wdata[1]),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_PERF_EN
    , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1),
    .stall_cnt0(stall_cnt0), .stall_cnt1(stall_cnt1)
`endif
  );

  always #5 clk = ~clk;

  // Single-port memory: latches address/write at posedge, read data valid next cycle.
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 16'hA000 + 16'(i);
      mem[16'h0010] <= 16'h1234;
      mem_init <= 1'b1;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    raddr_q <= mem_addr;
  end
  assign mem_rdata = mem[raddr_q];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    own = -1; prio = 0; beats = 0;
    exp_rv = 2'b00; exp_rdata = '0; last_addr = '0; last_wdata = '0;
`ifdef DMEM_ARB_PERF_EN
    pg[0] = 0; pg[1] = 0; ps[0] = 0; ps[1] = 0;
`endif
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_gnt0", 32'(gnt0), 32'd0);
    chk("rst_gnt1", 32'(gnt1), 32'd0);
    chk("rst_rvalid0", 32'(rvalid0), 32'd0);
    chk("rst_rvalid1", 32'(rvalid1), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
`ifdef DMEM_ARB_PERF_EN
    chk("rst_grant_cnt1", grant_cnt1, 32'd0);
    chk("rst_stall_cnt1", stall_cnt1, 32'd0);
`endif
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // One clock cycle: sample 1ns after the negedge, check, advance model, wait for next negedge.
  task automatic step();
    #1;
    g = -1;
    if (own >= 0) begin
      if (req[own]) g = own;
    end else if (req == 2'b11) g = prio;
    else if (req[0]) g = 0;
    else if (req[1]) g = 1;
    obs_g0 = gnt0;
    obs_g1 = gnt1;
    we_cnt += int'(mem_we);
    chk("gnt0", 32'(gnt0), 32'(g == 0));
    chk("gnt1", 32'(gnt1), 32'(g == 1));
    chk("rvalid0", 32'(rvalid0), 32'(exp_rv[0]));
    chk("rvalid1", 32'(rvalid1), 32'(exp_rv[1]));
    chk("rdata", 32'(rdata), 32'(exp_rdata));
    if (g >= 0) begin
      last_addr  = addr[g];
      last_wdata = wdata[g];
    end
    chk("mem_we", 32'(mem_we), 32'((g >= 0) ? we[g] : 1'b0));
    chk("mem_addr", 32'(mem_addr), 32'(last_addr));
    chk("mem_wdata", 32'(mem_wdata), 32'(last_wdata));

    exp_rv = 2'b00;
    exp_rdata = '0;
    if (g >= 0) begin
      if (we[g]) ref_mem[addr[g]] = wdata[g];
      else begin
        exp_rv[g] = 1'b1;
        exp_rdata = ref_mem[addr[g]];
      end
      prio = 1 - g;
    end
    if (own >= 0) begin
      if (g < 0) own = -1;
      else begin
        beats++;
        if (!lock[g] || beats >= LOCK_MAX) own = -1;
      end
    end else if (g >= 0 && lock[g]) begin
      beats = 1;
      if (LOCK_MAX > 1) own = g;
    end
`ifdef DMEM_ARB_PERF_EN
    for (int p = 0; p < 2; p++) begin
      pg[p] += (g == p) ? 1 : 0;
      ps[p] += (req[p] && g != p) ? 1 : 0;
    end
`endif
    @(negedge clk);
  endtask

  initial begin
    addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
    for (int i = 0; i < 64; i++) ref_mem[i] = 16'hA000 + 16'(i);
    ref_mem[16'h0010] = 16'h1234;
    we_cnt = 0;
    model_reset();
    @(negedge clk);
    do_reset();

    // single read from port 0
    req = 2'b01; we = 2'b00; addr[0] = 16'h0010;
    step();
    chk("t1_gnt0", 32'(obs_g0), 32'd1);
    chk("t1_rvalid0", 32'(rvalid0), 32'd1);
    chk("t1_rdata", 32'(rdata), 32'h1234);
    chk("t1_rvalid1", 32'(rvalid1), 32'd0);
    req = 2'b00;
    step();

    // both ports reading, no lock: strict alternation
    do_reset();
    req = 2'b11; addr[0] = 16'h0012; addr[1] = 16'h0014;
    hist0 = '0; hist1 = '0;
    for (int i = 0; i < 4; i++) begin
      step();
      hist0[i] = obs_g0;
      hist1[i] = obs_g1;
    end
    chk("rr_seq0", 32'(hist0), 32'h005);
    chk("rr_seq1", 32'(hist1), 32'h00A);
    chk("rr_last_rv1", 32'(rvalid1), 32'd1);
    req = 2'b00;
    step();

    // port 1 locked burst capped at LOCK_MAX beats
    do_reset();
    req = 2'b01; lock = 2'b00;
    step();
    req = 2'b11; lock = 2'b10;
    hist0 = '0; hist1 = '0;
    for (int i = 0; i < 12; i++) begin
      step();
      hist0[i] = obs_g0;
      hist1[i] = obs_g1;
    end
    chk("lock_seq1", 32'(hist1), 32'hEFF);
    chk("lock_seq0", 32'(hist0), 32'h100);
    req = 2'b00; lock = 2'b00;
    step();

    // write then read same address
    req = 2'b01; we = 2'b01; addr[0] = 16'h0020; wdata[0] = 16'hBEEF; we_cnt = 0;
    step();
    we = 2'b00;
    step();
    chk("raw_rvalid0", 32'(rvalid0), 32'd1);
    chk("raw_rdata", 32'(rdata), 32'hBEEF);
    req = 2'b00;
    step();
    step();
    chk("we_pulse", 32'(we_cnt), 32'd1);

    // reset in the middle of a port 1 lock with a read in flight
    req = 2'b10; lock = 2'b10; we = 2'b00; addr[1] = 16'h0014;
    step();
    step();
    chk("pre_rst_rv1", 32'(rvalid1), 32'd1);
    do_reset();
    req = 2'b11; lock = 2'b00;
    step();
    chk("post_rst_tie", 32'(obs_g0), 32'd1);
    req = 2'b00;
    step();

`ifdef DMEM_ARB_PERF_EN
    do_reset();
    req = 2'b11; lock = 2'b01;
    step();
    step();
    lock = 2'b00;
    step();
    req = 2'b10;
    for (int i = 0; i < 5; i++) step();
    req = 2'b00;
    step();
    chk("perf_grant1", grant_cnt1, 32'd5);
    chk("perf_stall1", stall_cnt1, 32'd3);
`endif

    // randomized traffic; requests held until granted
    do_reset();
    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < 2; p++) begin
        if (!req[p] && $urandom_range(0, 3) != 0) begin
          req[p]   = 1'b1;
          we[p]    = ($urandom_range(0, 2) == 0);
          addr[p]  = 16'h0010 + 16'(2 * $urandom_range(0, 7));
          wdata[p] = 16'($urandom);
        end
        lock[p] = ($urandom_range(0, 2) != 0);
      end
      step();
      if (g >= 0) req[g] = 1'b0;
    end
    req = 2'b00; lock = 2'b00;
    step();
`ifdef DMEM_ARB_PERF_EN
    chk("rand_grant0", grant_cnt0, 32'(pg[0]));
    chk("rand_grant1", grant_cnt1, 32'(pg[1]));
    chk("rand_stall0", stall_cnt0, 32'(ps[0]));
    chk("rand_stall1", stall_cnt1, 32'(ps[1]));
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port request/grant arbiter that shares the single-port data memory between port 0 (CPU load/store unit) and port 1 (debug/loader master).
- Sits between the requesters and the data memory macro. Drives its address, write-data and write-enable lines, and routes read data back with a one-cycle valid strobe.
- Round-robin fairness; a port may lock the memory for a bounded burst.

Parameters:
- DATA_WIDTH, 16, width of the data word.
- ADDR_WIDTH, 16, byte-address width presented to memory.
- LOCK_MAX, 8, maximum consecutive granted beats under lock before forced release.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- req0 / req1  in  1  access request, per port
- lock0 / lock1  in  1  hold ownership after this beat, per port
- we0 / we1  in  1  write (1) or read (0), per port
- addr0 / addr1  in  ADDR_WIDTH  byte address, per port
- wdata0 / wdata1  in  DATA_WIDTH  write data, per port
- gnt0 / gnt1  out  1  access accepted this cycle (combinational)
- rvalid0 / rvalid1  out  1  rdata valid for this port (registered)
- rdata  out  DATA_WIDTH  read data, shared by both ports
- mem_addr  out  ADDR_WIDTH  to memory address
- mem_wdata  out  DATA_WIDTH  to memory data input
- mem_we  out  1  to memory write enable
- mem_rdata  in  DATA_WIDTH  from memory data output

Behaviour:
- The memory latches address, data and write-enable at posedge. Read data is valid combinationally in the following cycle. One access is accepted per cycle.
- FSM states:
  - IDLE: no owner; the round-robin pointer prio says who wins a tie.
  - OWN0 / OWN1: the port holds the lock.
- Grant rules:
  - IDLE: single requester is granted. If both request, the port equal to prio is granted. On grant, prio flips to the other port.
  - OWNn: only port n can be granted; the other port's gnt is 0 even if it requests.
- Transitions:
  - IDLE -> OWNn when port n is granted with lockn=1.
  - OWNn -> IDLE on any of: lockn=0 on a granted beat; port n drops its request; lock beat counter reaches LOCK_MAX.
  - On forced release prio points to the other port, so the other port wins the next tie.
- Lock counter: ceil(log2(LOCK_MAX+1)) bits. Cleared on entry to OWNn, increments per granted beat. Does not wrap.
- Memory drive when gntn=1: mem_addr=addrn, mem_wdata=wdatan, mem_we=wen.
- Memory drive when no grant: mem_we=0, mem_addr and mem_wdata hold their previous registered values (registered mux select), so idle cycles cause no spurious writes.
- Read return:
  - rvalidn=1 exactly one cycle after a granted read (wen=0) on port n; rdata=mem_rdata in that cycle.
  - Writes produce no rvalid.
  - Back-to-back reads from either port give back-to-back rvalids.
- Read after write to the same address on consecutive cycles returns the new data (the memory commits the write before the read latch is used). The arbiter does no forwarding.
- Reset (async, rst=0): state=IDLE, prio=0, lock counter=0, gnt*=0, rvalid*=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata=0.
- Reset mid-burst: lock abandoned. A read accepted in the cycle before reset produces no rvalid.
- Requesters must hold req, addr, wdata and we stable until granted.

Optional Feature:
- Macro: DMEM_ARB_PERF_EN.
- Defined: adds outputs grant_cnt0, grant_cnt1, stall_cnt0, stall_cnt1 (32 bits each, reset 0, saturating at all ones).
  - grant_cnt counts gnt cycles.
  - stall_cnt counts cycles with req=1 and gnt=0.
- Undefined: these ports and counters do not exist; behaviour otherwise identical.

Decomposition:
- Shared package, added to the common types header: DATA_WIDTH and ADDR_WIDTH defaults, the arbiter state enum (IDLE, OWN0, OWN1), and port index constants.
- Sub-module: dmem_arb_rr, holding prio and the lock counter and computing the grant vector from req, lock and state. The top-level holds the memory mux, registered drive and rvalid pipeline.

Test Plan:
- Reset then req0 read addr 0x0010, memory preloaded 0x1234 -> gnt0 same cycle; next cycle rvalid0=1, rdata=0x1234, rvalid1=0.
- req0 and req1 held on reads for 4 cycles, no lock -> grants alternate 0,1,0,1; rvalids follow one cycle later in the same order.
- Port 1 with lock1=1 for 12 beats, port 0 requesting throughout, LOCK_MAX=8 -> port 1 gets 8 consecutive grants; next grant goes to port 0; gnt0=0 during the burst.
- Port 0 writes 0xBEEF to 0x0020, then reads 0x0020 next cycle -> rvalid0 with rdata=0xBEEF; mem_we=1 for exactly one cycle.
- rst asserted low mid-lock after a granted read -> all outputs zero immediately, no rvalid after release; first post-reset tie goes to port 0.
- With DMEM_ARB_PERF_EN: 5 grants and 3 stalls on port 1 -> grant_cnt1=5, stall_cnt1=3.
